aes128_decrypt_iter: RTL and testbench



---
 rtl/aes128_decrypt_iter.sv | 176 +++++++++++++++++
 tb/tb_aes128_decrypt_iter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_decrypt_iter.sv
`default_nettype none
// ============================================================================
// Module      : aes128_decrypt_iter
// Description : Iterative AES-128 inverse cipher, one round per clock, with
//               round keys fetched from an external store by index.
//               Optional macro AES_DEC_CLEAR_EN hides intermediate state.
// Revision    : 1.0 - initial release
// ============================================================================
module aes128_decrypt_iter #(
    parameter int ROUNDS   = 10,
    parameter int RK_IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        ciphertext,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [127:0]        rk_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        plaintext,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [RK_IDX_W-1:0] c_LAST_RK = RK_IDX_W'(ROUNDS);
    localparam logic [RK_IDX_W-1:0] c_ONE     = RK_IDX_W'(1);

    localparam logic [7:0] c_INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] aes_inv_sbox(input logic [7:0] b);
        return c_INV_SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiplies built from x2/x4/x8 partial products: 9, b, d, e.
    function automatic logic [31:0] aes_inv_mixcolumns(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m2 [4];
        logic [7:0] m4 [4];
        logic [7:0] m8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            m2[i] = xtime(a[i]);
            m4[i] = xtime(m2[i]);
            m8[i] = xtime(m4[i]);
            m9[i] = m8[i] ^ a[i];
            mb[i] = m8[i] ^ m2[i] ^ a[i];
            md[i] = m8[i] ^ m4[i] ^ a[i];
            me[i] = m8[i] ^ m4[i] ^ m2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    state_t                r_fsm;
    logic [RK_IDX_W-1:0]   r_cnt;
    logic [127:0]          r_state;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_busy;

    logic [127:0]          w_isb;
    logic [127:0]          w_t;
    logic [127:0]          w_mix;

    // Byte index is 4*col + row; InvShiftRows pulls from column (col - row) mod 4.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int SRC = 4 * ((c + 4 - r) % 4) + r;
            localparam int DST = 4 * c + r;
            assign w_isb[127-8*DST -: 8] = aes_inv_sbox(r_state[127-8*SRC -: 8]);
        end
        assign w_mix[127-32*c -: 32] = aes_inv_mixcolumns(w_t[127-32*c -: 32]);
    end

    assign w_t = w_isb ^ rk_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= S_IDLE;
            r_cnt       <= c_LAST_RK;
            r_state     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_state    <= ciphertext ^ rk_data;
                        r_cnt      <= c_LAST_RK - c_ONE;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_fsm      <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (r_cnt == '0) begin
                        r_state     <= w_t;
                        r_cnt       <= c_LAST_RK;
                        r_out_valid <= 1'b1;
                        r_fsm       <= S_DONE;
                    end else begin
                        r_state <= w_mix;
                        r_cnt   <= r_cnt - c_ONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
`ifdef AES_DEC_CLEAR_EN
                        r_state <= '0;
`endif
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_fsm       <= S_IDLE;
                    end
                end
                default: begin
                    r_fsm       <= S_IDLE;
                    r_cnt       <= c_LAST_RK;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Counter parks at the final key index outside ROUND, so rk_idx is 10 in IDLE.
    assign rk_idx    = r_cnt;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

`ifdef AES_DEC_CLEAR_EN
    assign plaintext = r_out_valid ? r_state : '0;
`else
    assign plaintext = r_state;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes128_decrypt_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes128_decrypt_iter
// Description : Directed and randomised checks of aes128_decrypt_iter against
//               a forward-cipher reference model and FIPS-197 vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes128_decrypt_iter;

    localparam logic [127:0] c_KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ciphertext;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox [256];
    logic [127:0] rk   [16];

    always #5 clk = ~clk;

    // Round-key store: answers the requested index in the same cycle.
    always_comb rk_data = rk[rk_idx];

    aes128_decrypt_iter #(
        .ROUNDS   (10),
        .RK_IDX_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .rk_idx     (rk_idx),
        .rk_data    (rk_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // Forward S-box from the field inverse (x^254) followed by the affine map.
    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] x;
            logic [7:0] inv;
            logic [7:0] s;
            x   = 8'(v);
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, x);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
            sbox[v] = s ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] res;
        for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ rk[0][127-8*b -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c+row] = sbox[s[4*((c+row)%4)+row]];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c+0] = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int row = 0; row < 4; row++) s[4*c+row] = t[4*c+row];
                end
            end
            for (int b = 0; b < 16; b++) s[b] = s[b] ^ rk[r][127-8*b -: 8];
        end
        for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
        return res;
    endfunction

    // Entered and left on a falling edge with the DUT idle.
    task automatic decrypt(input logic [127:0] ct, input logic [127:0] exp_pt, input int stall,
                           input bit detail, input bit offer, input logic [127:0] offer_ct);
        int lat;
        if (detail) begin
            check("in_ready_idle", 128'(in_ready), 128'(1));
            check("rk_idx_idle", 128'(rk_idx), 128'(10));
        end
        in_valid   = 1'b1;
        ciphertext = ct;
        out_ready  = 1'b0;
        @(negedge clk);
        in_valid   = 1'b0;
        ciphertext = '0;
        if (detail) begin
            check("busy_round", 128'(busy), 128'(1));
            check("in_ready_round", 128'(in_ready), 128'(0));
`ifdef AES_DEC_CLEAR_EN
            check("pt_hidden_round", plaintext, 128'h0);
`else
            check("pt_round_state", plaintext, ct ^ rk[10]);
`endif
        end
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (detail) check("rk_idx_round", 128'(rk_idx), 128'(9 - lat));
            else        out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        out_ready = 1'b0;
        check("latency", 128'(lat), 128'(10));
        for (int s = 0; s < stall; s++) begin
            if (offer) begin
                in_valid   = 1'b1;
                ciphertext = offer_ct;
            end
            if (detail) begin
                check("hold_out_valid", 128'(out_valid), 128'(1));
                check("hold_plaintext", plaintext, exp_pt);
                check("hold_in_ready", 128'(in_ready), 128'(0));
            end
            @(negedge clk);
        end
        in_valid   = 1'b0;
        ciphertext = '0;
        check("plaintext", plaintext, exp_pt);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (detail) begin
            check("in_ready_after", 128'(in_ready), 128'(1));
            check("out_valid_after", 128'(out_valid), 128'(0));
            check("busy_after", 128'(busy), 128'(0));
`ifdef AES_DEC_CLEAR_EN
            check("pt_cleared", plaintext, 128'h0);
`else
            check("pt_retained", plaintext, exp_pt);
`endif
        end
    endtask

    initial begin
        logic [127:0] ct2;
        logic [127:0] key;
        logic [127:0] pt;
        int           w;
        bit           seen;

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        ciphertext = '0;
        for (int r = 0; r < 16; r++) rk[r] = 128'h0;
        build_sbox();

        repeat (2) @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_rk_idx", 128'(rk_idx), 128'(10));
        check("rst_plaintext", plaintext, 128'h0);
        rst = 1'b0;
        @(negedge clk);

        expand(c_KEY_C1);
        decrypt(c_CT_C1, c_PT_C1, 0, 1'b1, 1'b0, 128'h0);

        expand(c_KEY_B);
        decrypt(c_CT_B, c_PT_B, 2, 1'b1, 1'b0, 128'h0);

        // Backpressure with a second block offered while DONE, then back-to-back.
        expand(c_KEY_C1);
        ct2 = encrypt(c_PT_B);
        decrypt(c_CT_C1, c_PT_C1, 20, 1'b1, 1'b1, ct2);
        decrypt(ct2, c_PT_B, 0, 1'b1, 1'b0, 128'h0);

        // Reset in the middle of a block.
        in_valid   = 1'b1;
        ciphertext = c_CT_C1;
        @(negedge clk);
        in_valid   = 1'b0;
        w = 0;
        while (rk_idx != 4'd5 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("reach_round5", 128'(rk_idx), 128'(5));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 128'(in_ready), 128'(1));
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_rk_idx", 128'(rk_idx), 128'(10));
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_plaintext", plaintext, 128'h0);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_output", 128'(seen), 128'(0));
        decrypt(c_CT_C1, c_PT_C1, 0, 1'b1, 1'b0, 128'h0);

        for (int i = 0; i < 1000; i++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            expand(key);
            decrypt(encrypt(pt), pt, $urandom_range(0, 3), 1'b0, 1'b0, 128'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
